// File: rtl/e203_dma_mover_if.sv
// ICB command/response channel between the DMA data mover (master) and the bus fabric (slave).
interface e203_dma_mover_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [ADDR_W-1:0]   cmd_addr;
   logic                cmd_read;
   logic [DATA_W-1:0]   cmd_wdata;
   logic [DATA_W/8-1:0] cmd_wmask;
   logic                rsp_valid;
   logic                rsp_ready;
   logic                rsp_err;
   logic [DATA_W-1:0]   rsp_rdata;

   modport master (
      output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
      output cmd_ready, rsp_valid, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/e203_dma_mover.sv
// E203 DMA data mover: copies cfg_len words from source to destination, one read then one write per word.
//
// state  | meaning
// IDLE   | waiting for cfg_start
// RD_CMD | read command for rd_addr on the bus
// RD_RSP | waiting for read data
// WR_CMD | write command of the buffered word to wr_addr
// WR_RSP | waiting for write acknowledge
// FIN    | dma_irq high for one cycle, then back to IDLE
module e203_dma_mover #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] cfg_src_addr,
   input  logic [ADDR_W-1:0] cfg_dst_addr,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              cfg_start,
   output logic              busy,
   output logic              err,
   output logic              dma_irq,
   e203_dma_mover_if.master  icb
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_CMD = 3'd1,
      RD_RSP = 3'd2,
      WR_CMD = 3'd3,
      WR_RSP = 3'd4,
      FIN    = 3'd5
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   rd_addr;
   logic [ADDR_W-1:0]   wr_addr;
   logic [LEN_W-1:0]    remaining;
   logic [DATA_W-1:0]   data_buf;
   logic                cmd_valid_q;
   logic                cmd_read_q;
   logic [ADDR_W-1:0]   cmd_addr_q;
   logic [DATA_W/8-1:0] cmd_wmask_q;
   logic                rsp_ready_q;

   assign icb.cmd_valid = cmd_valid_q;
   assign icb.cmd_read  = cmd_read_q;
   assign icb.cmd_addr  = cmd_addr_q;
   assign icb.cmd_wdata = data_buf;
   assign icb.cmd_wmask = cmd_wmask_q;
   assign icb.rsp_ready = rsp_ready_q;

   // Command fields are loaded on entry to a CMD state, so they cannot move while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rd_addr     <= '0;
         wr_addr     <= '0;
         remaining   <= '0;
         data_buf    <= '0;
         busy        <= 1'b0;
         err         <= 1'b0;
         dma_irq     <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_read_q  <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wmask_q <= '0;
         rsp_ready_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_start) begin
                  err  <= 1'b0;
                  busy <= 1'b1;
                  if (cfg_len != '0) begin
                     rd_addr     <= cfg_src_addr;
                     wr_addr     <= cfg_dst_addr;
                     remaining   <= cfg_len;
                     cmd_valid_q <= 1'b1;
                     cmd_read_q  <= 1'b1;
                     cmd_addr_q  <= cfg_src_addr;
                     cmd_wmask_q <= '0;
                     state       <= RD_CMD;
                  end else begin
                     dma_irq <= 1'b1;
                     state   <= FIN;
                  end
               end
            end
            RD_CMD: begin
               if (icb.cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  rsp_ready_q <= 1'b1;
                  state       <= RD_RSP;
               end
            end
            RD_RSP: begin
               if (icb.rsp_valid) begin
                  rsp_ready_q <= 1'b0;
                  if (icb.rsp_err) begin
                     err     <= 1'b1;
                     dma_irq <= 1'b1;
                     state   <= FIN;
                  end else begin
                     data_buf    <= icb.rsp_rdata;
                     rd_addr     <= rd_addr + ADDR_W'(4);
                     cmd_valid_q <= 1'b1;
                     cmd_read_q  <= 1'b0;
                     cmd_addr_q  <= wr_addr;
                     cmd_wmask_q <= '1;
                     state       <= WR_CMD;
                  end
               end
            end
            WR_CMD: begin
               if (icb.cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  rsp_ready_q <= 1'b1;
                  state       <= WR_RSP;
               end
            end
            WR_RSP: begin
               if (icb.rsp_valid) begin
                  rsp_ready_q <= 1'b0;
                  wr_addr     <= wr_addr + ADDR_W'(4);
                  remaining   <= remaining - LEN_W'(1);
                  if (icb.rsp_err) begin
                     err     <= 1'b1;
                     dma_irq <= 1'b1;
                     state   <= FIN;
                  end else if (remaining == LEN_W'(1)) begin
                     dma_irq <= 1'b1;
                     state   <= FIN;
                  end else begin
                     cmd_valid_q <= 1'b1;
                     cmd_read_q  <= 1'b1;
                     cmd_addr_q  <= rd_addr;
                     cmd_wmask_q <= '0;
                     state       <= RD_CMD;
                  end
               end
            end
            FIN: begin
               dma_irq <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               busy        <= 1'b0;
               dma_irq     <= 1'b0;
               cmd_valid_q <= 1'b0;
               rsp_ready_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
